// File: rtl/loop_ctrl_if.sv
// Bundle of the loop controller's button, codec and sound RAM signals.
// The slave modport is the controller's view; master is the surrounding system.
interface loop_ctrl_if;
    logic        rec_btn;
    logic        play_btn;
    logic        stop_btn;
    logic        in_valid;
    logic [23:0] in_sample;
    logic        out_ready;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;
    logic [23:0] out_sample;
    logic        out_valid;
    logic [15:0] loop_len;
    logic [1:0]  state;

    modport slave (
        input  rec_btn, play_btn, stop_btn, in_valid, in_sample, out_ready, ram_rdata,
        output ram_addr, ram_we, ram_wdata, out_sample, out_valid, loop_len, state
    );

    modport master (
        output rec_btn, play_btn, stop_btn, in_valid, in_sample, out_ready, ram_rdata,
        input  ram_addr, ram_we, ram_wdata, out_sample, out_valid, loop_len, state
    );
endinterface

// File: rtl/loop_ctrl.sv
// Audio loop recorder: records codec samples into an external sound RAM and
// plays them back cyclically, with a two-cycle fetch pipeline toward the codec.
module loop_ctrl #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    loop_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);
    localparam logic [15:0] FULL_LEN  = 16'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] rec_ptr_q, rec_ptr_d;
    logic [15:0] play_ptr_q, play_ptr_d;
    logic [15:0] loop_len_q, loop_len_d;
    logic        fetch_q, fetch_d;
    logic        silent_q, silent_d;
    logic [23:0] out_sample_q, out_sample_d;
    logic        out_valid_q, out_valid_d;

    logic        wr_en;
    logic [15:0] rec_cnt;
    logic        accept;

    always_comb begin
        state_d      = state_q;
        rec_ptr_d    = rec_ptr_q;
        play_ptr_d   = play_ptr_q;
        loop_len_d   = loop_len_q;

        wr_en   = (state_q == RECORD) && bus.in_valid;
        rec_cnt = rec_ptr_q + {15'd0, wr_en};

        // A request is only taken while neither pipeline stage is busy.
        accept      = bus.out_ready && !fetch_q && !out_valid_q;
        fetch_d     = accept;
        silent_d    = (state_q != PLAY);
        out_valid_d = fetch_q;
        out_sample_d = out_sample_q;
        if (fetch_q) begin
            out_sample_d = silent_q ? '0 : bus.ram_rdata;
        end

        case (state_q)
            IDLE: begin
                if (bus.stop_btn) begin
                    state_d = IDLE;
                end else if (bus.rec_btn) begin
                    state_d   = RECORD;
                    rec_ptr_d = '0;
                end else if (bus.play_btn && (loop_len_q != '0)) begin
                    state_d    = PLAY;
                    play_ptr_d = '0;
                end
            end
            RECORD: begin
                if (bus.stop_btn) begin
                    loop_len_d = rec_cnt;
                    play_ptr_d = '0;
                    state_d    = (rec_cnt != '0) ? PLAY : IDLE;
                end else if (wr_en && (rec_ptr_q == LAST_ADDR)) begin
                    loop_len_d = FULL_LEN;
                    play_ptr_d = '0;
                    state_d    = PLAY;
                end else begin
                    rec_ptr_d = rec_cnt;
                end
            end
            PLAY: begin
                if (bus.stop_btn) begin
                    state_d = IDLE;
                end else if (bus.rec_btn) begin
                    state_d   = RECORD;
                    rec_ptr_d = '0;
                end else if (accept) begin
                    play_ptr_d = (play_ptr_q == loop_len_q - 16'd1) ? '0 : play_ptr_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rec_ptr_q    <= '0;
            play_ptr_q   <= '0;
            loop_len_q   <= '0;
            fetch_q      <= 1'b0;
            silent_q     <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_ptr_q    <= rec_ptr_d;
            play_ptr_q   <= play_ptr_d;
            loop_len_q   <= loop_len_d;
            fetch_q      <= fetch_d;
            silent_q     <= silent_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.ram_we     = wr_en && !reset;
    assign bus.ram_addr   = (state_q == RECORD) ? rec_ptr_q : play_ptr_q;
    assign bus.ram_wdata  = bus.in_sample;
    assign bus.out_sample = out_sample_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.loop_len   = loop_len_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_loop_ctrl.sv
// Vector table plus output scoreboard for loop_ctrl with a behavioural
// registered-read sound RAM.
module tb_loop_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   nwrites;
    int   bad_writes;

    loop_ctrl_if bus ();

    loop_ctrl #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [23:0] mem [0:255];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            nwrites <= nwrites + 1;
            if (bus.ram_addr >= 16'd64) bad_writes <= bad_writes + 1;
        end
        bus.ram_rdata <= mem[bus.ram_addr[7:0]];
    end

    typedef struct {
        logic        rst, rec, play, stop, iv;
        logic [23:0] smp;
        logic        ordy, push;
        logic [23:0] pval;
        logic        chk, we;
        logic [15:0] addr;
        logic [1:0]  st;
        logic [15:0] len;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [23:0] val;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl [17];

    function automatic vec_t mk(input logic rst, rec, play, stop, iv, input int smp,
                                input logic ordy, push, input int pval,
                                input logic chk, we, input int addr, st, len);
        vec_t v;
        v.rst = rst; v.rec = rec; v.play = play; v.stop = stop; v.iv = iv;
        v.smp = 24'(smp); v.ordy = ordy; v.push = push; v.pval = 24'(pval);
        v.chk = chk; v.we = we; v.addr = 16'(addr); v.st = 2'(st); v.len = 16'(len);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs and scoreboard, then registers.
    task automatic step(input vec_t v);
        reset         = v.rst;
        bus.rec_btn   = v.rec;
        bus.play_btn  = v.play;
        bus.stop_btn  = v.stop;
        bus.in_valid  = v.iv;
        bus.in_sample = v.smp;
        bus.out_ready = v.ordy;
        if (v.rst) sbq.delete();
        else if (v.ordy && v.push) sbq.push_back('{cyc + 2, v.pval});
        #3;
        if (v.chk) begin
            check("ram_we", 32'(bus.ram_we), 32'(v.we));
            check("ram_addr", 32'(bus.ram_addr), 32'(v.addr));
            if (v.we) check("ram_wdata", 32'(bus.ram_wdata), 32'(v.smp));
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            check("out_valid_pulse", 32'(bus.out_valid), 32'd1);
            check("out_sample", 32'(bus.out_sample), 32'(sbq[0].val));
            void'(sbq.pop_front());
        end else begin
            check("out_valid_idle", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        if (v.chk) begin
            check("state", 32'(bus.state), 32'(v.st));
            check("loop_len", 32'(bus.loop_len), 32'(v.len));
        end
    endtask

    int          w0;
    int          ref_loop [3];
    vec_t        v;

    initial begin
        cyc = 0; checks = 0; errors = 0; nwrites = 0; bad_writes = 0;
        reset = 1'b1;
        bus.rec_btn = 0; bus.play_btn = 0; bus.stop_btn = 0;
        bus.in_valid = 0; bus.in_sample = '0; bus.out_ready = 0;
        ref_loop[0] = 10; ref_loop[1] = 20; ref_loop[2] = 30;

        //              rst rec ply stp iv smp ordy push pval chk we addr st len
        tbl[0]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 20, 0, 0, 0, 1, 1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 30, 0, 0, 0, 1, 1, 2, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 3, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 40, 0, 0, 0, 1, 1, 3, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 50, 0, 0, 0, 1, 1, 4, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1, 1, 99, 0, 0, 0, 1, 1, 5, 2, 6);
        tbl[8]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 6);
        tbl[9]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 6);
        tbl[10] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 6);
        tbl[11] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 6);
        tbl[12] = mk(0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 1, 0, 1, 6);
        tbl[13] = mk(0, 0, 0, 0, 1, 20, 0, 0, 0, 1, 1, 1, 1, 6);
        tbl[14] = mk(0, 0, 0, 0, 1, 30, 1, 1, 0, 1, 1, 2, 1, 6);
        tbl[15] = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 3, 2, 3);
        tbl[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 3);

        @(posedge clk);
        #1;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sample", 32'(bus.out_sample), 32'd0);

        for (int i = 0; i < 17; i++) step(tbl[i]);

        check("ram0", 32'(mem[0]), 32'd10);
        check("ram1", 32'(mem[1]), 32'd20);
        check("ram2", 32'(mem[2]), 32'd30);
        check("ram3", 32'(mem[3]), 32'd40);
        check("ram4", 32'(mem[4]), 32'd50);
        check("ram5", 32'(mem[5]), 32'd99);

        // Wrap playback: 7 requests, 8 cycles apart.
        for (int k = 0; k < 7; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 1, ref_loop[k % 3], 1, 0, k % 3, 2, 3));
            for (int j = 0; j < 7; j++)
                step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (k + 1) % 3, 2, 3));
        end

        // Requests while a fetch is in flight are dropped.
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 20, 1, 0, 1, 2, 3));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 2, 3));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 2, 3));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 2, 3));
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 30, 1, 0, 2, 2, 3));
        for (int j = 0; j < 3; j++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 3));

        // Empty recording, then reset overriding a record write.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        step(mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0));
        check("ram0_kept", 32'(mem[0]), 32'd10);

        // Full loop: 70 samples offered, only 64 written.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        w0 = nwrites;
        for (int i = 0; i < 70; i++) begin
            if (i < 64) v = mk(0, 0, 0, 0, 1, 1000 + i, 0, 0, 0, 1, 1, i,
                               (i < 63) ? 1 : 2, (i < 63) ? 0 : 64);
            else        v = mk(0, 0, 0, 0, 1, 1000 + i, 0, 0, 0, 1, 0, 0, 2, 64);
            step(v);
        end
        check("full_writes", 32'(nwrites - w0), 32'd64);
        check("full_bad_addr", 32'(bad_writes), 32'd0);
        check("full_ram63", 32'(mem[63]), 32'd1063);
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1000, 1, 0, 0, 2, 64));
        for (int j = 0; j < 3; j++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 64));

        // Reset one cycle after a request cancels the fetch.
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1001, 1, 0, 1, 2, 64));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_sample", 32'(bus.out_sample), 32'd0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loop_ctrl.md
LOOP_CTRL -- requirements
Module: loop_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the loop capacity in samples; the sound RAM addresses used SHALL be 0..DEPTH-1.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rec_btn  input  1  one-cycle pulse: start recording.
REQ-005 play_btn  input  1  one-cycle pulse: start playback.
REQ-006 stop_btn  input  1  one-cycle pulse: stop recording or playback.
REQ-007 in_valid  input  1  one-cycle pulse: in_sample holds a new codec sample.
REQ-008 in_sample  input  24  signed audio sample from the codec.
REQ-009 out_ready  input  1  one-cycle pulse: codec requests the next output sample.
REQ-010 ram_addr  output  16  sound RAM address (combinational).
REQ-011 ram_we  output  1  sound RAM write enable (combinational).
REQ-012 ram_wdata  output  24  sound RAM write data (combinational, equals in_sample).
REQ-013 ram_rdata  input  24  sound RAM registered read data; valid one cycle after the address is presented.
REQ-014 out_sample  output  24  registered sample to the codec.
REQ-015 out_valid  output  1  one-cycle pulse: out_sample is updated.
REQ-016 loop_len  output  16  registered count of recorded samples, 0..DEPTH.
REQ-017 state  output  2  IDLE=0, RECORD=1, PLAY=2; value 3 SHALL never occur.

Function
REQ-018 State machine SHALL have states IDLE, RECORD and PLAY, with registers rec_ptr and play_ptr of 16 bits each.
REQ-019 Button priority within a cycle SHALL be stop_btn > rec_btn > play_btn.
REQ-020 IDLE + rec_btn SHALL go to RECORD with rec_ptr=0.
REQ-021 PLAY + rec_btn (no stop_btn) SHALL go to RECORD with rec_ptr=0, overwriting the previous loop.
REQ-022 IDLE + play_btn with loop_len>0 SHALL go to PLAY with play_ptr=0; with loop_len=0 it SHALL be ignored.
REQ-023 RECORD + in_valid SHALL, in the same cycle, drive ram_we=1, ram_addr=rec_ptr and ram_wdata=in_sample; rec_ptr SHALL then increment at the clock edge.
REQ-024 ram_we SHALL be 0 in every other cycle.
REQ-025 RECORD + stop_btn SHALL set loop_len to the number of samples written, including any in_valid write in the same cycle.
REQ-026 After REQ-025, the block SHALL go to PLAY with play_ptr=0 if loop_len>0, else to IDLE.
REQ-027 Full condition: when the write at rec_ptr=DEPTH-1 occurs, the block SHALL set loop_len=DEPTH and go to PLAY with play_ptr=0 in the same edge; further in_valid pulses SHALL not write.
REQ-028 PLAY + stop_btn SHALL go to IDLE; loop_len SHALL be retained.
REQ-029 ram_addr SHALL equal rec_ptr in RECORD and play_ptr otherwise.
REQ-030 PLAY + out_ready at cycle N SHALL advance play_ptr at the end of N, to play_ptr+1, or to 0 when play_ptr=loop_len-1 (wrap).
REQ-031 Output timing: ram_rdata SHALL be captured at the end of N+1, giving out_sample = RAM[old play_ptr] and out_valid=1 during N+2 only (2-cycle latency).
REQ-032 out_ready in IDLE or RECORD SHALL produce out_sample=0 and out_valid=1 during N+2 (silence, same latency).
REQ-033 out_ready arriving while a fetch is in flight (cycles N+1, N+2) SHALL be ignored.
REQ-034 A fetch in flight SHALL complete normally across a state change.
REQ-035 Simultaneous in_valid and out_ready in RECORD SHALL perform the write and return silence per REQ-032.

Reset
REQ-036 Reset SHALL set state=IDLE, rec_ptr=0, play_ptr=0, loop_len=0, out_sample=0 and out_valid=0, and cancel any fetch in flight.
REQ-037 Reset SHALL not clear RAM contents.
REQ-038 Reset SHALL take priority over all other inputs; during reset ram_we=0.

Verification
REQ-039 Record short loop: rec_btn, then in_valid with 10,20,30, then stop_btn -> RAM[0..2]=10,20,30, loop_len=3, state=PLAY.
REQ-040 Wrap playback: loop from REQ-039 plus 7 out_ready pulses spaced 8 cycles apart -> out_sample 10,20,30,10,20,30,10, each with out_valid exactly 2 cycles after its out_ready.
REQ-041 Full: DEPTH=64, rec_btn, then 70 in_valid pulses -> exactly 64 writes (addresses 0..63), loop_len=64, PLAY entered on the 64th write, no write to address 64.
REQ-042 Empty: rec_btn then immediate stop_btn -> loop_len=0, state=IDLE; a following play_btn leaves state=IDLE.
REQ-043 Simultaneous: in RECORD with rec_ptr=5, in_valid(value 99) and stop_btn in one cycle -> RAM[5]=99, loop_len=6, state=PLAY.
REQ-044 Mid-operation reset: reset asserted one cycle after an out_ready in PLAY -> no out_valid pulse; all outputs at reset values next cycle; state=IDLE.
